// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: synchronises PLL lock, waits for stable lock, then
// releases NUM_CH domain resets one after another. Any loss of lock puts
// every domain back into reset.
// Optional feature macro: LOCK_LOSS_CNT_EN (saturating lock-loss counter;
// when undefined, lock_loss_cnt is tied to zero and no counter flops exist).
module pll_reset_sequencer #(
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned STAGGER_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              ready,
  output logic [7:0]        lock_loss_cnt
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned STG_W  = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [STG_W-1:0]       stg_cnt_q, stg_cnt_d;
  logic [NUM_CH-1:0]      ch_q, ch_d;
  logic                   ready_q, ready_d;

  // Lock synchroniser: shift pll_locked through SYNC_STAGES flops
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next-state and next-output logic; lock loss beats soft reset beats progress
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stg_cnt_d  = stg_cnt_q;
    ch_d       = ch_q;
    ready_d    = ready_q;

    if (state_q == ST_IDLE) begin
      ch_d       = '0;
      ready_d    = 1'b0;
      hold_cnt_d = '0;
      stg_cnt_d  = '0;
      if (lock_s) begin
        state_d = ST_HOLD;
      end
    end else if (!lock_s) begin
      state_d    = ST_IDLE;
      ch_d       = '0;
      ready_d    = 1'b0;
      hold_cnt_d = '0;
      stg_cnt_d  = '0;
    end else if (soft_rst_req) begin
      state_d    = ST_HOLD;
      ch_d       = '0;
      ready_d    = 1'b0;
      hold_cnt_d = '0;
      stg_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            stg_cnt_d  = '0;
            ch_d       = NUM_CH'(1);
            if (NUM_CH == 1) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            hold_cnt_d = HOLD_W'(hold_cnt_q + 1'b1);
          end
        end
        ST_RELEASE: begin
          if (stg_cnt_q == STG_LAST) begin
            stg_cnt_d = '0;
            ch_d      = NUM_CH'({ch_q, 1'b1});
            if (ch_d[NUM_CH-1]) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end
          end else begin
            stg_cnt_d = STG_W'(stg_cnt_q + 1'b1);
          end
        end
        default: begin
          // ST_RUN: outputs hold their values
        end
      endcase
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      stg_cnt_q  <= '0;
      ch_q       <= '0;
      ready_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
      ch_q       <= ch_d;
      ready_q    <= ready_d;
    end
  end

  assign ch_rst_n = ch_q;
  assign ready    = ready_q;

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Saturating count of lock losses seen outside IDLE
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if ((state_q != ST_IDLE) && !lock_s && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = 8'(loss_cnt_q + 8'd1);
    end
  end

  // Lock-loss counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= 8'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule
